wbh_reg_init: RTL and testbench



---
 rtl/wbh_reg_init_if.sv | 47 ++++
 rtl/wbh_reg_init.sv | 147 ++++++++++++++
 tb/tb_wbh_reg_init.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbh_reg_init_if.sv
//------------------------------------------------------------------------------
// Module   : wbh_reg_init_if
// Brief    : Wishbone slave port plus reg-bus initiator signals for wbh_reg_init.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wbh_reg_init_if #(
  parameter int AW = 3
) ();

  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic            wbs_we_i;
  logic [31:0]     wbs_adr_i;
  logic [31:0]     wbs_dat_i;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  logic            reg_cs;
  logic            reg_wr;
  logic [AW-1:0]   reg_addr;
  logic [31:0]     reg_wdata;
  logic [3:0]      reg_be;
  logic [31:0]     reg_rdata;
  logic            reg_ack;

  // slave: the bridge itself; master: Wishbone master plus reg-bus responder
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  reg_rdata, reg_ack,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output reg_rdata, reg_ack,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
  );

endinterface

`default_nettype wire

// File: rtl/wbh_reg_init.sv
//------------------------------------------------------------------------------
// Module   : wbh_reg_init
// Brief    : Wishbone classic slave to single-outstanding reg-bus initiator
//            with access timeout and saturating error counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wbh_reg_init #(
  parameter int AW      = 3,
  parameter int TMO_CYC = 16
) (
  input  logic              mclk,
  input  logic              reset_n,
  wbh_reg_init_if.slave     bus,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] c_tmo_last = 8'(TMO_CYC - 1);

  state_t          r_state,     w_state;
  logic            r_reg_cs,    w_reg_cs;
  logic            r_reg_wr,    w_reg_wr;
  logic [AW-1:0]   r_reg_addr,  w_reg_addr;
  logic [31:0]     r_reg_wdata, w_reg_wdata;
  logic [3:0]      r_reg_be,    w_reg_be;
  logic [31:0]     r_dat_o,     w_dat_o;
  logic            r_ack,       w_ack;
  logic            r_err,       w_err;
  logic [7:0]      r_err_cnt,   w_err_cnt;
  logic [7:0]      r_tmo_cnt,   w_tmo_cnt;
  logic            r_abort,     w_abort;

  // byte-lane and out-of-window address bits carry no meaning on the reg bus
  logic            w_unused_adr;
  assign w_unused_adr = ^{bus.wbs_adr_i[31:AW+2], bus.wbs_adr_i[1:0]};

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_reg_cs    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_be    <= '0;
      r_dat_o     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_reg_cs    <= w_reg_cs;
      r_reg_wr    <= w_reg_wr;
      r_reg_addr  <= w_reg_addr;
      r_reg_wdata <= w_reg_wdata;
      r_reg_be    <= w_reg_be;
      r_dat_o     <= w_dat_o;
      r_ack       <= w_ack;
      r_err       <= w_err;
      r_err_cnt   <= w_err_cnt;
      r_tmo_cnt   <= w_tmo_cnt;
      r_abort     <= w_abort;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_reg_cs    = r_reg_cs;
    w_reg_wr    = r_reg_wr;
    w_reg_addr  = r_reg_addr;
    w_reg_wdata = r_reg_wdata;
    w_reg_be    = r_reg_be;
    w_dat_o     = r_dat_o;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_err_cnt   = r_err_cnt;
    w_tmo_cnt   = r_tmo_cnt;
    w_abort     = r_abort;

    case (r_state)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          w_reg_cs    = 1'b1;
          w_reg_wr    = bus.wbs_we_i;
          w_reg_addr  = bus.wbs_adr_i[AW+1:2];
          w_reg_wdata = bus.wbs_dat_i;
          w_reg_be    = bus.wbs_sel_i;
          w_tmo_cnt   = '0;
          w_abort     = 1'b0;
          w_state     = ST_REQ;
        end
      end

      ST_REQ: begin
        // once the master walks away, the reg access finishes silently
        w_abort = r_abort | ~bus.wbs_cyc_i;
        if (bus.reg_ack) begin
          w_reg_cs = 1'b0;
          if (!w_abort) begin
            w_ack = 1'b1;
            if (!r_reg_wr) begin
              w_dat_o = bus.reg_rdata;
            end
          end
          w_state = ST_RESP;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_reg_cs  = 1'b0;
          w_err     = ~w_abort;
          w_err_cnt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
          w_state   = ST_RESP;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 8'd1;
        end
      end

      ST_RESP: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_reg_cs = 1'b0;
        w_state  = ST_IDLE;
      end
    endcase
  end

  assign bus.reg_cs    = r_reg_cs;
  assign bus.reg_wr    = r_reg_wr;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.reg_be    = r_reg_be;
  assign bus.wbs_dat_o = r_dat_o;
  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_err_o = r_err;
  assign err_cnt       = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wbh_reg_init.sv
// Testbench for wbh_reg_init: table of Wishbone accesses against a stub
// responder, a response scoreboard, and hand sequences for abort/reset/timeouts.
`default_nettype none

module tb_wbh_reg_init;

  localparam int AW  = 3;
  localparam int TMO = 16;

  logic       mclk    = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] err_cnt;

  always #5 mclk = ~mclk;

  wbh_reg_init_if #(.AW(AW)) bus ();

  wbh_reg_init #(.AW(AW), .TMO_CYC(TMO)) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // stub responder: acks rsp_delay cycles after first seeing reg_cs, never if negative
  int          rsp_delay = 0;
  logic [31:0] rsp_rdata = '0;
  logic        late_ack  = 1'b0;
  logic        r_ack;
  logic [31:0] r_rdata;
  int          rsp_cnt;
  int          rsp_acks = 0;

  always @(posedge mclk) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      rsp_cnt <= 0;
    end else begin
      r_ack <= 1'b0;
      if (bus.reg_cs && !r_ack) begin
        if (rsp_delay >= 0 && rsp_cnt == rsp_delay) begin
          r_ack    <= 1'b1;
          r_rdata  <= rsp_rdata;
          rsp_acks <= rsp_acks + 1;
        end
        rsp_cnt <= rsp_cnt + 1;
      end else if (!bus.reg_cs) begin
        rsp_cnt <= 0;
      end
    end
  end

  assign bus.reg_ack   = r_ack | late_ack;
  assign bus.reg_rdata = r_ack ? r_rdata : 32'hBAD0_BAD0;

  // scoreboard of expected Wishbone responses
  typedef struct {
    logic        is_err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_pulses  = 0;
  logic [31:0] m_dat     = '0;
  int          m_err_cnt = 0;

  always @(negedge mclk) begin
    if (bus.wbs_ack_o || bus.wbs_err_o) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({bus.wbs_ack_o, bus.wbs_err_o}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_err",   32'(bus.wbs_err_o), 32'(mon_e.is_err));
        chk("sb_ack",   32'(bus.wbs_ack_o), 32'(!mon_e.is_err));
        chk("sb_dat_o", bus.wbs_dat_o, mon_e.dat);
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  task automatic drive(input vec_t v);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = v.we;
    bus.wbs_adr_i = v.adr;
    bus.wbs_dat_i = v.dat;
    bus.wbs_sel_i = v.sel;
    rsp_delay     = v.delay;
    rsp_rdata     = v.rdata;
  endtask

  task automatic release_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask

  // b2b: driven during the previous access's response cycle; keep: leave strobe up
  task automatic access(input vec_t v, input bit b2b, input bit keep);
    int   n;
    int   acks0;
    bit   done;
    exp_t e;
    drive(v);
    acks0    = rsp_acks;
    e.is_err = v.exp_err;
    if (!v.we && !v.exp_err) m_dat = v.rdata;
    e.dat = m_dat;
    if (v.exp_err) m_err_cnt = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;
    sb.push_back(e);
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge mclk);
      n++;
      if (b2b && n == 1) chk({v.name, "_cs_gap"}, 32'(bus.reg_cs), 32'd0);
      if (n == (b2b ? 2 : 1)) begin
        chk({v.name, "_cs"},    32'(bus.reg_cs),   32'd1);
        chk({v.name, "_addr"},  32'(bus.reg_addr), v.exp_addr);
        chk({v.name, "_wr"},    32'(bus.reg_wr),   32'(v.we));
        chk({v.name, "_wdata"}, bus.reg_wdata,     v.dat);
        chk({v.name, "_be"},    32'(bus.reg_be),   32'(v.sel));
      end
      done = bus.wbs_ack_o | bus.wbs_err_o;
    end
    chk({v.name, "_latency"}, 32'(n), 32'(v.exp_lat + (b2b ? 1 : 0)));
    chk({v.name, "_cs_drop"}, 32'(bus.reg_cs), 32'd0);
    chk({v.name, "_err_cnt"}, 32'(err_cnt), 32'(m_err_cnt));
    chk({v.name, "_rsp_acks"}, 32'(rsp_acks - acks0), 32'((v.delay >= 0) ? 1 : 0));
    if (!keep) begin
      release_bus();
      @(negedge mclk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_reg_cs"},    32'(bus.reg_cs),    32'd0);
    chk({tag, "_reg_wr"},    32'(bus.reg_wr),    32'd0);
    chk({tag, "_ack"},       32'(bus.wbs_ack_o), 32'd0);
    chk({tag, "_err"},       32'(bus.wbs_err_o), 32'd0);
    chk({tag, "_reg_addr"},  32'(bus.reg_addr),  32'd0);
    chk({tag, "_reg_wdata"}, bus.reg_wdata,      32'd0);
    chk({tag, "_reg_be"},    32'(bus.reg_be),    32'd0);
    chk({tag, "_dat_o"},     bus.wbs_dat_o,      32'd0);
    chk({tag, "_err_cnt"},   32'(err_cnt),       32'd0);
  endtask

  // abort: master drops cyc in cycle 1; reg access must still run to its end
  task automatic abort_access(input string name, input int delay, input bit is_tmo);
    int   n;
    int   acks0;
    int   p0;
    vec_t v;
    v = '{name, 1'b0, 32'h0000_0004, 32'h0, 4'hF, delay, 32'h7777_7777, 32'd1, 0, 1'b0};
    drive(v);
    acks0 = rsp_acks;
    p0    = n_pulses;
    @(negedge mclk);
    chk({name, "_cs"}, 32'(bus.reg_cs), 32'd1);
    release_bus();
    n = 1;
    while (bus.reg_cs && n < 40) begin
      @(negedge mclk);
      n++;
    end
    if (is_tmo) m_err_cnt = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;
    chk({name, "_end_cycle"}, 32'(n), 32'(is_tmo ? TMO + 1 : delay + 3));
    repeat (2) @(negedge mclk);
    chk({name, "_rsp_acks"}, 32'(rsp_acks - acks0), 32'(is_tmo ? 0 : 1));
    chk({name, "_no_pulse"}, 32'(n_pulses - p0), 32'd0);
    chk({name, "_dat_o"},    bus.wbs_dat_o, m_dat);
    chk({name, "_err_cnt"},  32'(err_cnt),  32'(m_err_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 0x%08h expected 0x%08h", n_checks, 0);
    $fatal(1, "watchdog");
  end

  vec_t vt[7];
  vec_t rd_a, rd_b, tmo_v;

  initial begin
    vt[0] = '{"rd_0x4",   1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF,  0, 32'h0000_1000, 32'd1,  3, 1'b0};
    vt[1] = '{"wr_0x8",   1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 4'hF,  0, 32'h1111_1111, 32'd2,  3, 1'b0};
    vt[2] = '{"rd_hiadr", 1'b0, 32'hFFFF_FFEF, 32'h0000_0000, 4'h3,  2, 32'h1234_5678, 32'd3,  5, 1'b0};
    vt[3] = '{"wr_sel0",  1'b1, 32'h0000_001C, 32'hDEAD_BEEF, 4'h0,  0, 32'h2222_2222, 32'd7,  3, 1'b0};
    vt[4] = '{"rd_tmo",   1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, -1, 32'h3333_3333, 32'd4, 17, 1'b1};
    vt[5] = '{"rd_last",  1'b0, 32'h0000_0014, 32'h0000_0000, 4'hF, 14, 32'hCAFE_F00D, 32'd5, 17, 1'b0};
    vt[6] = '{"wr_d13",   1'b1, 32'h0000_0018, 32'h0BAD_F00D, 4'hC, 13, 32'h4444_4444, 32'd6, 16, 1'b0};
    rd_a  = '{"b2b_a",    1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF,  0, 32'hAAAA_0001, 32'd2,  3, 1'b0};
    rd_b  = '{"b2b_b",    1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF,  0, 32'hBBBB_0002, 32'd3,  3, 1'b0};
    tmo_v = '{"tmo_sat",  1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, -1, 32'h0,         32'd0, 17, 1'b1};

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;

    repeat (3) @(negedge mclk);
    chk_reset("reset");
    reset_n = 1'b1;
    @(negedge mclk);

    for (int i = 0; i < 7; i++) access(vt[i], 1'b0, 1'b0);

    // late ack in the cycle after the timeout response is ignored
    access(vt[4], 1'b0, 1'b1);
    release_bus();
    @(posedge mclk);
    #1 late_ack = 1'b1;
    @(posedge mclk);
    #1 late_ack = 1'b0;
    @(negedge mclk);
    chk("late_ack_cs",      32'(bus.reg_cs), 32'd0);
    chk("late_ack_err_cnt", 32'(err_cnt),    32'(m_err_cnt));
    chk("late_ack_dat_o",   bus.wbs_dat_o,   m_dat);
    @(negedge mclk);

    abort_access("abort_rd",  2, 1'b0);
    abort_access("abort_tmo", -1, 1'b1);

    // reset in cycle 1 of an access, then two back-to-back reads
    drive(vt[0]);
    @(negedge mclk);
    chk("rst_mid_cs_before", 32'(bus.reg_cs), 32'd1);
    reset_n = 1'b0;
    release_bus();
    @(negedge mclk);
    m_dat     = '0;
    m_err_cnt = 0;
    chk_reset("rst_mid");
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    access(rd_a, 1'b0, 1'b1);
    access(rd_b, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) access(tmo_v, 1'b0, 1'b0);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    repeat (3) @(negedge mclk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
